// File: rtl/if_pkg.sv
// if_pkg: shared definitions for the instruction fetch stage.
package if_pkg;

    // Width of one instruction word
    localparam int unsigned INST_W = 32;

    // Default first fetch address after reset
    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

    // Byte distance between consecutive instructions
    localparam int unsigned PC_INC = 4;

    // Fetch FSM: no fetch outstanding / fetch in flight / flushed fetch in flight
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDrop = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_fifo.sv
// if_fifo: 2-entry {pc, inst} buffer between memctrl responses and the decode stage.
// Flush empties the buffer in the same cycle; callers never push when full or pop when empty.
module if_fifo #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic [DATA_W-1:0] push_inst_i,
    input  logic              pop_i,
    output logic              empty_o,
    output logic              full_o,
    output logic [ADDR_W-1:0] head_pc_o,
    output logic [DATA_W-1:0] head_inst_o
);

    logic [ADDR_W-1:0] pc_mem_q   [2];
    logic [DATA_W-1:0] inst_mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;

    // Storage, pointers and occupancy; flush drops everything but leaves payload stale
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                pc_mem_q[wr_ptr_q]   <= push_pc_i;
                inst_mem_q[wr_ptr_q] <= push_inst_i;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign empty_o     = (count_q == 2'd0);
    assign full_o      = (count_q == 2'd2);
    assign head_pc_o   = pc_mem_q[rd_ptr_q];
    assign head_inst_o = inst_mem_q[rd_ptr_q];

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage. Requests words from memctrl at the fetch PC, keeps at
// most one fetch outstanding and handles redirects, including ones that land while a fetch
// is in flight (the late response is discarded).
// Build option: define IF_PREFETCH_EN to place a 2-entry prefetch FIFO in front of decode;
// without it a single output register holds at most one instruction.
module if_stage
    import if_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    input  logic              mem_req_i,
    input  logic              mc_busy_i,
    input  logic              mc_done_i,
    input  logic [INST_W-1:0] mc_data_i,
    output logic              if_re_o,
    output logic [ADDR_W-1:0] if_addr_o,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o
);

    if_state_e         state_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic              slot_free;
    logic              accept;
    logic              word_ok;

    // Request is gated by rdy so memctrl never accepts a fetch this stage fails to record
    assign if_re_o   = !rst && rdy && (state_q == StIdle) && !branch_i && slot_free;
    assign accept    = if_re_o && !mem_req_i && !mc_busy_i;
    assign if_addr_o = fetch_pc_q;
    // Response that is actually kept; a coincident redirect wins over the returning word
    assign word_ok   = (state_q == StWait) && mc_done_i && !branch_i;

    // Fetch FSM and fetch PC
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
        end else if (rdy) begin
            if (branch_i) begin
                fetch_pc_q <= branch_addr_i;
            end else if (word_ok) begin
                fetch_pc_q <= fetch_pc_q + ADDR_W'(PC_INC);
            end
            unique case (state_q)
                StIdle: if (accept) state_q <= StWait;
                StWait: begin
                    if (mc_done_i) begin
                        state_q <= StIdle;
                    end else if (branch_i) begin
                        state_q <= StDrop;
                    end
                end
                StDrop: if (mc_done_i) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef IF_PREFETCH_EN
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_pop;
    logic [ADDR_W-1:0] fifo_pc;
    logic [INST_W-1:0] fifo_inst;

    // A head entry leaving this cycle makes room even when the FIFO is full
    assign fifo_pop  = rdy && !branch_i && !fifo_empty && !stall_i;
    assign slot_free = !fifo_full || (!fifo_empty && !stall_i);

    if_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (INST_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (rdy && branch_i),
        .push_i      (rdy && word_ok),
        .push_pc_i   (fetch_pc_q),
        .push_inst_i (mc_data_i),
        .pop_i       (fifo_pop),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .head_pc_o   (fifo_pc),
        .head_inst_o (fifo_inst)
    );

    assign inst_valid_o = !fifo_empty;
    assign inst_o       = fifo_inst;
    assign pc_o         = fifo_pc;
`else
    // The slot is free when empty or when decode takes the held word this cycle
    assign slot_free = !inst_valid_o || !stall_i;

    // Single output register: load on kept response, hold under stall, drop on redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            pc_o         <= '0;
        end else if (rdy) begin
            if (branch_i) begin
                inst_valid_o <= 1'b0;
            end else if (word_ok) begin
                inst_valid_o <= 1'b1;
                inst_o       <= mc_data_i;
                pc_o         <= fetch_pc_q;
            end else if (!stall_i) begin
                inst_valid_o <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed tests for if_stage in its default build (no prefetch FIFO).
// A small memctrl model answers each accepted fetch LAT cycles later.
module tb_if_stage;

    localparam int unsigned LAT = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        mem_req_i;
    logic        mc_busy_i;
    logic        mc_done_i;
    logic [31:0] mc_data_i;
    logic        if_re_o;
    logic [31:0] if_addr_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    int          n_tests = 0;
    int          n_fail  = 0;

    // memctrl model state (written only by the model process)
    int          acc_cnt;
    logic [31:0] acc_addr [64];
    bit          pend;
    int          cnt;
    logic [31:0] pend_addr;

    if_stage #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .stall_i       (stall_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .mem_req_i     (mem_req_i),
        .mc_busy_i     (mc_busy_i),
        .mc_done_i     (mc_done_i),
        .mc_data_i     (mc_data_i),
        .if_re_o       (if_re_o),
        .if_addr_o     (if_addr_o),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0004) return 32'h0000_0013;
        return a ^ 32'hA5A5_0000;
    endfunction

    // memctrl model: decides acceptance mid-cycle, raises done for the LAT-th edge after it
    initial begin : mem_model
        mc_done_i = 1'b0;
        mc_data_i = '0;
        acc_cnt   = 0;
        pend      = 1'b0;
        cnt       = 0;
        pend_addr = '0;
        forever begin
            @(negedge clk);
            mc_done_i = 1'b0;
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    mc_done_i = 1'b1;
                    mc_data_i = mem_word(pend_addr);
                    pend      = 1'b0;
                end
            end
            if (if_re_o && !mem_req_i && !mc_busy_i) begin
                pend                 = 1'b1;
                cnt                  = LAT;
                pend_addr            = if_addr_o;
                acc_addr[acc_cnt%64] = if_addr_o;
                acc_cnt              = acc_cnt + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset long enough for any in-flight model response to drain
    task automatic do_reset();
        rst           = 1'b1;
        rdy           = 1'b1;
        stall_i       = 1'b0;
        branch_i      = 1'b0;
        branch_addr_i = '0;
        mem_req_i     = 1'b0;
        mc_busy_i     = 1'b0;
        repeat (8) tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(output bit found, output int n);
        found = 1'b0;
        n     = 0;
        while (!found && n < 40) begin
            tick();
            n++;
            if (inst_valid_o) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; stall_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
        mem_req_i = 1'b0; mc_busy_i = 1'b0;
        tick();
        n_tests++;
        if (if_re_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_if_re: got %b want 0", if_re_o);
        end
        n_tests++;
        if (inst_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid_o);
        end
        n_tests++;
        if (inst_o !== 32'h0 || pc_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_outputs: inst %h pc %h want 0 0", inst_o, pc_o);
        end
        repeat (7) tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if (if_re_o !== 1'b1 || if_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_first_req: re %b addr %h want 1 0", if_re_o, if_addr_o);
        end
    endtask

    task automatic test_fetch_seq();
        bit found;
        int n;
        int base;
        do_reset();
        base = acc_cnt;
        for (int k = 0; k < 3; k++) begin
            wait_valid(found, n);
            n_tests++;
            if (!found || pc_o !== 32'(4 * k) || inst_o !== mem_word(32'(4 * k))) begin
                n_fail++;
                $display("FAIL seq_word%0d: valid %b pc %h inst %h want pc %h inst %h",
                         k, found, pc_o, inst_o, 32'(4 * k), mem_word(32'(4 * k)));
            end
            n_tests++;
            if (n != ((k == 0) ? 6 : 5)) begin
                n_fail++; $display("FAIL seq_latency%0d: got %0d want %0d", k, n, (k == 0) ? 6 : 5);
            end
            tick();
            n_tests++;
            if (inst_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL seq_pulse%0d: valid %b want 0", k, inst_valid_o);
            end
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (acc_addr[(base + k) % 64] !== 32'(4 * k)) begin
                n_fail++;
                $display("FAIL seq_if_addr%0d: got %h want %h", k, acc_addr[(base + k) % 64], 32'(4 * k));
            end
        end
    endtask

    task automatic test_mem_req();
        bit found;
        int n;
        int base;
        do_reset();
        mem_req_i = 1'b1;
        base = acc_cnt;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (if_re_o !== 1'b1 || if_addr_o !== 32'h0) begin
                n_fail++; $display("FAIL memreq_hold%0d: re %b addr %h want 1 0", i, if_re_o, if_addr_o);
            end
            tick();
        end
        n_tests++;
        if (acc_cnt != base) begin
            n_fail++; $display("FAIL memreq_no_accept: accepts %0d want 0", acc_cnt - base);
        end
        mem_req_i = 1'b0;
        wait_valid(found, n);
        n_tests++;
        if (!found || pc_o !== 32'h0 || n != 6) begin
            n_fail++; $display("FAIL memreq_accept: valid %b pc %h cycles %0d want 1 0 6", found, pc_o, n);
        end
    endtask

    task automatic test_branch();
        bit found;
        int n;
        int base;
        do_reset();
        base = acc_cnt;
        for (int i = 0; i < 60 && acc_cnt < base + 3; i++) tick();
        n_tests++;
        if (acc_cnt < base + 3) begin
            n_fail++; $display("FAIL branch_wait_pc8: accepts %0d want 3", acc_cnt - base);
        end
        repeat (2) tick();
        branch_i      = 1'b1;
        branch_addr_i = 32'h0000_0100;
        tick();
        branch_i = 1'b0;
        wait_valid(found, n);
        n_tests++;
        if (!found || pc_o !== 32'h100 || inst_o !== mem_word(32'h100)) begin
            n_fail++;
            $display("FAIL branch_target: valid %b pc %h inst %h want pc 100 inst %h",
                     found, pc_o, inst_o, mem_word(32'h100));
        end
        n_tests++;
        if (acc_addr[(base + 3) % 64] !== 32'h100) begin
            n_fail++; $display("FAIL branch_req_addr: got %h want 100", acc_addr[(base + 3) % 64]);
        end
    endtask

    task automatic test_stall();
        bit found;
        int n;
        int base;
        do_reset();
        base = acc_cnt;
        wait_valid(found, n);
        wait_valid(found, n);
        n_tests++;
        if (!found || pc_o !== 32'h4) begin
            n_fail++; $display("FAIL stall_setup: valid %b pc %h want 1 4", found, pc_o);
        end
        stall_i = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (inst_valid_o !== 1'b1 || pc_o !== 32'h4 || inst_o !== 32'h0000_0013) begin
                n_fail++;
                $display("FAIL stall_hold%0d: valid %b pc %h inst %h want 1 4 00000013",
                         i, inst_valid_o, pc_o, inst_o);
            end
            n_tests++;
            if (if_re_o !== 1'b0) begin
                n_fail++; $display("FAIL stall_no_req%0d: re %b want 0", i, if_re_o);
            end
            tick();
        end
        n_tests++;
        if (acc_cnt != base + 2) begin
            n_fail++; $display("FAIL stall_accepts: got %0d want 2", acc_cnt - base);
        end
        stall_i = 1'b0;
        #1;
        n_tests++;
        if (if_re_o !== 1'b1 || if_addr_o !== 32'h8) begin
            n_fail++; $display("FAIL stall_release: re %b addr %h want 1 8", if_re_o, if_addr_o);
        end
        wait_valid(found, n);
        n_tests++;
        if (!found || pc_o !== 32'h8) begin
            n_fail++; $display("FAIL stall_next: valid %b pc %h want 1 8", found, pc_o);
        end
    endtask

    task automatic test_rdy();
        bit found;
        int n;
        int base;
        do_reset();
        base = acc_cnt;
        wait_valid(found, n);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (inst_valid_o !== 1'b1 || pc_o !== 32'h0 || if_addr_o !== 32'h4) begin
                n_fail++;
                $display("FAIL rdy_hold%0d: valid %b pc %h addr %h want 1 0 4",
                         i, inst_valid_o, pc_o, if_addr_o);
            end
        end
        n_tests++;
        if (acc_cnt != base + 1) begin
            n_fail++; $display("FAIL rdy_accepts: got %0d want 1", acc_cnt - base);
        end
        rdy = 1'b1;
        tick();
        n_tests++;
        if (inst_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rdy_resume: valid %b want 0", inst_valid_o);
        end
        wait_valid(found, n);
        n_tests++;
        if (!found || pc_o !== 32'h4) begin
            n_fail++; $display("FAIL rdy_next: valid %b pc %h want 1 4", found, pc_o);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        int n;
        int base;
        do_reset();
        base = acc_cnt;
        repeat (4) tick();
        rst       = 1'b1;
        mc_busy_i = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (inst_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_stray: valid %b pc %h want valid 0", inst_valid_o, pc_o);
        end
        n_tests++;
        if (acc_cnt != base + 1) begin
            n_fail++; $display("FAIL rstmid_accepts: got %0d want 1", acc_cnt - base);
        end
        mc_busy_i = 1'b0;
        #1;
        n_tests++;
        if (if_re_o !== 1'b1 || if_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_restart: re %b addr %h want 1 0", if_re_o, if_addr_o);
        end
        wait_valid(found, n);
        n_tests++;
        if (!found || pc_o !== 32'h0 || inst_o !== mem_word(32'h0)) begin
            n_fail++; $display("FAIL rstmid_word: valid %b pc %h inst %h want pc 0", found, pc_o, inst_o);
        end
    endtask

    task automatic test_branch_done();
        bit found;
        bit seen;
        int n;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (mc_done_i) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL brdone_wait: done %b want 1", seen);
        end
        branch_i      = 1'b1;
        branch_addr_i = 32'h0000_0200;
        tick();
        branch_i = 1'b0;
        n_tests++;
        if (inst_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL brdone_discard: valid %b pc %h want valid 0", inst_valid_o, pc_o);
        end
        #1;
        n_tests++;
        if (if_re_o !== 1'b1 || if_addr_o !== 32'h200) begin
            n_fail++; $display("FAIL brdone_req: re %b addr %h want 1 200", if_re_o, if_addr_o);
        end
        wait_valid(found, n);
        n_tests++;
        if (!found || pc_o !== 32'h200 || inst_o !== mem_word(32'h200)) begin
            n_fail++; $display("FAIL brdone_word: valid %b pc %h inst %h want pc 200", found, pc_o, inst_o);
        end
    endtask

    task automatic test_wrap();
        bit found;
        int n;
        do_reset();
        branch_i      = 1'b1;
        branch_addr_i = 32'hFFFF_FFFC;
        #1;
        n_tests++;
        if (if_re_o !== 1'b0) begin
            n_fail++; $display("FAIL wrap_branch_no_req: re %b want 0", if_re_o);
        end
        tick();
        branch_i = 1'b0;
        #1;
        n_tests++;
        if (if_addr_o !== 32'hFFFF_FFFC || if_re_o !== 1'b1) begin
            n_fail++; $display("FAIL wrap_target: re %b addr %h want 1 fffffffc", if_re_o, if_addr_o);
        end
        wait_valid(found, n);
        n_tests++;
        if (!found || pc_o !== 32'hFFFF_FFFC || if_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_pc: valid %b pc %h next %h want 1 fffffffc 0", found, pc_o, if_addr_o);
        end
        wait_valid(found, n);
        n_tests++;
        if (!found || pc_o !== 32'h0) begin
            n_fail++; $display("FAIL wrap_next: valid %b pc %h want 1 0", found, pc_o);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_seq();
        test_mem_req();
        test_branch();
        test_stall();
        test_rdy();
        test_reset_mid();
        test_branch_done();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter ADDR_W, default 32, width of PC and memctrl address.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 rdy  input  1  global enable; when 0, all state and outputs hold.
REQ-006 stall_i  input  1  decode stage cannot accept; held instruction stays on outputs.
REQ-007 branch_i  input  1  redirect/flush request, one-cycle pulse.
REQ-008 branch_addr_i  input  ADDR_W  redirect target.
REQ-009 mem_req_i  input  1  MEM stage is driving memctrl this cycle; memctrl serves MEM first.
REQ-010 mc_busy_i  input  1  memctrl busy_o.
REQ-011 mc_done_i  input  1  memctrl done_o.
REQ-012 mc_data_i  input  32  memctrl data_o, instruction word.
REQ-013 if_re_o  output  1  fetch request to memctrl.
REQ-014 if_addr_o  output  ADDR_W  fetch address, always equal to fetch PC.
REQ-015 inst_valid_o  output  1  inst_o/pc_o hold a valid instruction.
REQ-016 inst_o  output  32  fetched instruction.
REQ-017 pc_o  output  ADDR_W  address of inst_o.

Function
REQ-018 FSM states: IDLE (no fetch outstanding), WAIT (fetch accepted, awaiting done), DROP (fetch accepted but flushed by redirect, awaiting done to discard).
REQ-019 Acceptance: a fetch is accepted at a posedge where if_re_o=1, mem_req_i=0, mc_busy_i=0; only then IDLE->WAIT.
REQ-020 IDLE: if_re_o=1 when no branch_i and the output slot is free or being consumed this cycle (stall_i=0); otherwise if_re_o=0.
REQ-021 if_re_o stays asserted from IDLE until accepted; fetch PC does not change while requesting, except on branch_i.
REQ-022 WAIT: first mc_done_i=1 belongs to the fetch; load inst_o<=mc_data_i, pc_o<=fetch PC, inst_valid_o<=1, fetch PC<=fetch PC+4, go IDLE; if_re_o=0 in WAIT.
REQ-023 Output hold: while stall_i=1 and inst_valid_o=1, inst_o/pc_o/inst_valid_o unchanged; when stall_i=0 and no new word arrives, inst_valid_o<=0.
REQ-024 Redirect in IDLE: fetch PC<=branch_addr_i, inst_valid_o<=0, no request issued that cycle.
REQ-025 Redirect in WAIT: fetch PC<=branch_addr_i, inst_valid_o<=0, go DROP; data of the matching done is discarded, then go IDLE.
REQ-026 Redirect in DROP: fetch PC<=branch_addr_i, remain DROP.
REQ-027 branch_i coincident with mc_done_i in WAIT: redirect wins, word discarded, go IDLE.
REQ-028 PC arithmetic modulo 2^ADDR_W; wrap from all-ones-minus-3 to 0 without special handling.
REQ-029 Minimum fetch latency: request cycle to inst_valid_o equals memctrl latency +1 cycle (registered output).

Reset
REQ-030 On rst=1 at posedge: state<=IDLE, fetch PC<=RESET_PC, inst_valid_o<=0, inst_o<=0, pc_o<=0; if_re_o=0 during reset cycle.
REQ-031 Reset mid-WAIT abandons the fetch; a later stray mc_done_i in IDLE is ignored.
REQ-032 rst has priority over rdy.

Configuration
REQ-033 Macro IF_PREFETCH_EN: when defined, a 2-entry instruction FIFO sits between memctrl response and outputs; fetching continues while stall_i=1 until FIFO full (counting outstanding fetch); branch_i empties FIFO in the same cycle.
REQ-034 Without IF_PREFETCH_EN: single output register only, at most one instruction buffered, behaviour per REQ-020..REQ-027.
REQ-035 With macro, FIFO-full plus outstanding fetch blocks if_re_o; FIFO empty gives inst_valid_o=0.

Structure
REQ-036 Shared package if_pkg: FSM state encoding, RESET_PC default, instruction width 32, PC increment 4.
REQ-037 Sub-module if_fifo (2-entry, {pc,inst} payload, flush input) instantiated only under IF_PREFETCH_EN.

Verification
REQ-038 Reset, RESET_PC=0, memctrl done 5 cycles after accept, stall_i=0 -> if_addr_o 0,4,8 in order; inst_valid_o pulses with pc_o 0,4,8.
REQ-039 mem_req_i=1 for 3 cycles while if_re_o=1 -> no acceptance, if_addr_o stable, acceptance on first cycle mem_req_i=0.
REQ-040 branch_i to 32'h100 while WAIT for pc 8 -> word for 8 never on inst_o; next valid pc_o=32'h100.
REQ-041 stall_i=1 for 4 cycles with inst 32'h00000013 at pc 4 -> outputs unchanged; no if_re_o without macro; with IF_PREFETCH_EN, fetches 8 and 12 then if_re_o=0.
REQ-042 rst asserted in WAIT, stray mc_done_i next cycle -> inst_valid_o=0, fetch restarts at RESET_PC.
REQ-043 branch_i and mc_done_i same cycle -> data discarded, next request at branch_addr_i.
